vxu_enq_queues: RTL
===================

# vxu_enq_queues

Command-queue and immediate-queue buffering stage directly downstream of the vector block decoder. It accepts one decoded instruction per cycle, enqueues its command word and/or first immediate into two independent FIFOs, and returns the replay indication when any required queue lacks space. Enqueue is all-or-nothing. The two FIFOs drain to the sequencer through independent valid/ready ports.

## Interface
- CMD_W, 20: command word width
- IMM_W, 64: immediate width
- CMDQ_DEPTH, 4: command FIFO entries (≥2, any integer)
- XIMM1Q_DEPTH, 4: immediate FIFO entries (≥2, any integer)

- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- io_valid  in  1  decoded instruction present
- io_sigs_enq_cmdq  in  1  instruction requires a command-queue entry
- io_sigs_enq_ximm1q  in  1  instruction requires an immediate-queue entry
- io_cmd  in  CMD_W  command word
- io_imm1  in  IMM_W  first immediate
- io_replay  out  1  instruction not accepted this cycle
- io_cmdq_deq_valid  out  1  command FIFO head valid
- io_cmdq_deq_ready  in  1  consumer takes command head
- io_cmdq_deq_bits  out  CMD_W  command FIFO head
- io_ximm1q_deq_valid  out  1  immediate FIFO head valid
- io_ximm1q_deq_ready  in  1  consumer takes immediate head
- io_ximm1q_deq_bits  out  IMM_W  immediate FIFO head
- io_cmdq_count  out  clog2(CMDQ_DEPTH+1)  command occupancy
- io_ximm1q_count  out  clog2(XIMM1Q_DEPTH+1)  immediate occupancy

## Operation
- cmdq_ready = cmdq_count < CMDQ_DEPTH. ximm1q_ready = ximm1q_count < XIMM1Q_DEPTH. Both are registered-state only and never depend on the current-cycle dequeue.
- io_replay = io_valid && ((io_sigs_enq_cmdq && !cmdq_ready) || (io_sigs_enq_ximm1q && !ximm1q_ready)). It is combinational from the inputs and matches the decoder's replay equation.
- fire = io_valid && !io_replay.
- On fire, the command FIFO writes io_cmd when io_sigs_enq_cmdq is set. On fire, the immediate FIFO writes io_imm1 when io_sigs_enq_ximm1q is set.
- Atomicity: if either required queue is full, neither queue is written.
- io_valid with both sigs clear: fire is asserted, io_replay is low, and no write occurs.
- Each FIFO is a circular buffer with a read pointer, a write pointer and a count register.
  - Pointers wrap explicitly: the pointer returns to 0 when it equals DEPTH-1, so depth need not be a power of two.
  - deq_valid = count != 0.
  - A dequeue happens when deq_valid && deq_ready.
  - count_next = count + enq - deq.
- Full with a dequeue in the same cycle: no enqueue is allowed, because ready is low. The count decrements.
- Empty with an enqueue: there is no flow-through. deq_valid rises the following cycle.
- Enqueue and dequeue in the same cycle on a non-empty, non-full FIFO: the count is unchanged and both pointers advance.
- deq_ready asserted while deq_valid is low has no effect.
- Reset, including mid-operation: all pointers and counts clear to 0 and all contents are discarded. Storage is not reset.

## Timing
- Reset values:
  - io_cmdq_deq_valid = 0 and io_ximm1q_deq_valid = 0.
  - Both counts = 0.
  - io_replay = 0 when io_valid = 0.
  - deq_bits are don't-care while deq_valid = 0.
- Enqueue-to-deq_valid latency: 1 cycle.
- deq_bits is read from storage at the read pointer. It is stable while valid and not dequeued.
- Sustained throughput: 1 enqueue and 1 dequeue per cycle per FIFO.
- A replayed instruction is re-presented by upstream. Re-presenting is upstream's responsibility; this block does not hold it.

## Structure
- Package vxu_enq_pkg holds the CMD_W, IMM_W and depth defaults and the count-width helper.
- One generic sub-module, vxu_enq_fifo, with parameters W and DEPTH. It provides enq_valid and enq_bits inputs, a registered-state enq_ready output, a deq port and a count output.
- vxu_enq_fifo is instantiated twice. The top level holds only the replay/fire logic.

## Test plan
- After reset, present io_valid=1 with cmdq=1, ximm1q=1, cmd=0x00A5, imm1=0x1234 → io_replay=0. Next cycle both deq_valid=1, heads are 0x00A5 and 0x1234, and both counts are 1.
- Fill the cmdq with 4 commands while holding cmdq deq_ready=0, then present cmdq=1, ximm1q=1 → io_replay=1, ximm1q_count is unchanged at 0, and the command FIFO contents are intact.
- With the cmdq full and deq_ready=1, present a new command in the same cycle → replay=1 that cycle. The next cycle re-presented accepts, count returns to 4, and order is preserved.
- With DEPTH=3, perform 10 enqueue/dequeue pairs with values 0..9 → output order is 0..9. The pointers wrap correctly and the count never exceeds 3.
- Present io_valid=1 with both sigs 0 → replay=0 and both counts are unchanged.
- With the cmdq at 2 entries, assert reset for one cycle → next cycle both counts are 0 and deq_valid=0. The first subsequent enqueue appears at the head.

Source files
------------

// File: rtl/vxu_enq_pkg.sv
// Shared defaults for the vector enqueue stage.
//   DEF_CMD_W / DEF_IMM_W           : command word and immediate widths
//   DEF_CMDQ_DEPTH / DEF_XIMM1Q_DEPTH : FIFO entry counts (>= 2, any integer)
//   count_width()                   : bits needed to hold an occupancy of 0..depth
package vxu_enq_pkg;

    localparam int DEF_CMD_W        = 20;
    localparam int DEF_IMM_W        = 64;
    localparam int DEF_CMDQ_DEPTH   = 4;
    localparam int DEF_XIMM1Q_DEPTH = 4;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vxu_enq_fifo.sv
// Circular-buffer FIFO with explicit pointer wrap, so DEPTH need not be a
// power of two. No flow-through: an entry written this cycle is visible at
// the head the next cycle.
//   clk, reset          : clock, synchronous active-high reset
//   enq_valid/enq_bits  : write request and data (ignored when enq_ready is low)
//   enq_ready           : space available, from registered occupancy only
//   deq_valid/deq_ready : head present / consumer takes head
//   deq_bits            : head entry
//   count               : current occupancy
module vxu_enq_fifo
    import vxu_enq_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enq_valid,
    input  logic [W-1:0]                   enq_bits,
    output logic                           enq_ready,
    output logic                           deq_valid,
    input  logic                           deq_ready,
    output logic [W-1:0]                   deq_bits,
    output logic [count_width(DEPTH)-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             enq_s;
    logic             deq_s;

    // Advance a pointer, returning to zero after the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    assign enq_ready = (count_r < CNT_W'(DEPTH));
    assign deq_valid = (count_r != {CNT_W{1'b0}});
    assign enq_s     = enq_valid && enq_ready;
    assign deq_s     = deq_valid && deq_ready;
    assign deq_bits  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Occupancy update: +1 on enqueue, -1 on dequeue, unchanged on both or neither.
    always_comb begin
        count_next_s = count_r;
        case ({enq_s, deq_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; reset discards all contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_next_s;
            if (enq_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (deq_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
        end
    end

    // Storage array; deliberately not reset since validity is tracked by count.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_r[wr_ptr_r] <= enq_bits;
        end
    end

endmodule

// File: rtl/vxu_enq_queues.sv
// Command/immediate enqueue stage behind the vector decoder. One decoded
// instruction per cycle is written into the command FIFO and/or the first
// immediate FIFO. Enqueue is all-or-nothing: if any required queue is full the
// instruction is replayed and neither queue is written.
//   io_valid, io_sigs_enq_*, io_cmd, io_imm1 : decoded instruction
//   io_replay                                : instruction not accepted this cycle
//   io_cmdq_deq_*, io_ximm1q_deq_*           : independent valid/ready drain ports
//   io_cmdq_count, io_ximm1q_count           : occupancies
module vxu_enq_queues
    import vxu_enq_pkg::*;
#(
    parameter int CMD_W        = DEF_CMD_W,
    parameter int IMM_W        = DEF_IMM_W,
    parameter int CMDQ_DEPTH   = DEF_CMDQ_DEPTH,
    parameter int XIMM1Q_DEPTH = DEF_XIMM1Q_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  io_valid,
    input  logic                                  io_sigs_enq_cmdq,
    input  logic                                  io_sigs_enq_ximm1q,
    input  logic [CMD_W-1:0]                      io_cmd,
    input  logic [IMM_W-1:0]                      io_imm1,
    output logic                                  io_replay,
    output logic                                  io_cmdq_deq_valid,
    input  logic                                  io_cmdq_deq_ready,
    output logic [CMD_W-1:0]                      io_cmdq_deq_bits,
    output logic                                  io_ximm1q_deq_valid,
    input  logic                                  io_ximm1q_deq_ready,
    output logic [IMM_W-1:0]                      io_ximm1q_deq_bits,
    output logic [count_width(CMDQ_DEPTH)-1:0]    io_cmdq_count,
    output logic [count_width(XIMM1Q_DEPTH)-1:0]  io_ximm1q_count
);

    logic cmdq_ready_s;
    logic ximm1q_ready_s;
    logic fire_s;
    logic cmdq_enq_s;
    logic ximm1q_enq_s;

    // Readiness comes from registered occupancy only, so a same-cycle dequeue
    // never opens space; this keeps replay identical to the decoder's equation.
    assign io_replay    = io_valid &&
                          ((io_sigs_enq_cmdq   && !cmdq_ready_s) ||
                           (io_sigs_enq_ximm1q && !ximm1q_ready_s));
    assign fire_s       = io_valid && !io_replay;
    assign cmdq_enq_s   = fire_s && io_sigs_enq_cmdq;
    assign ximm1q_enq_s = fire_s && io_sigs_enq_ximm1q;

    vxu_enq_fifo #(
        .W     (CMD_W),
        .DEPTH (CMDQ_DEPTH)
    ) u_cmdq (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (cmdq_enq_s),
        .enq_bits  (io_cmd),
        .enq_ready (cmdq_ready_s),
        .deq_valid (io_cmdq_deq_valid),
        .deq_ready (io_cmdq_deq_ready),
        .deq_bits  (io_cmdq_deq_bits),
        .count     (io_cmdq_count)
    );

    vxu_enq_fifo #(
        .W     (IMM_W),
        .DEPTH (XIMM1Q_DEPTH)
    ) u_ximm1q (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (ximm1q_enq_s),
        .enq_bits  (io_imm1),
        .enq_ready (ximm1q_ready_s),
        .deq_valid (io_ximm1q_deq_valid),
        .deq_ready (io_ximm1q_deq_ready),
        .deq_bits  (io_ximm1q_deq_bits),
        .count     (io_ximm1q_count)
    );

endmodule
